// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if: decode/execute/writeback/branch signals of the issue controller.
// The slave modport is the controller side; master is the surrounding pipeline.
interface issue_ctrl_if #(
    parameter int n_regs_p = 32,
    parameter int wd_cnt_p = 16
);
    localparam int wd_addr_p = $clog2(n_regs_p);
    logic                 i_dec_valid;
    logic                 o_dec_ready;
    logic [wd_addr_p-1:0] i_rs1;
    logic [wd_addr_p-1:0] i_rs2;
    logic                 i_rs1_used;
    logic                 i_rs2_used;
    logic [wd_addr_p-1:0] i_rdest;
    logic                 i_rd_wr;
    logic                 i_jump;
    logic                 i_ex_ready;
    logic                 o_issue_valid;
    logic                 i_wb_valid;
    logic [wd_addr_p-1:0] i_wb_rdest;
    logic                 i_br_resolved;
    logic                 i_br_taken;
    logic                 o_flush;
    logic [n_regs_p-1:0]  o_busy_map;
    logic [wd_cnt_p-1:0]  o_stall_cnt;

    modport master (
        output i_dec_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used, i_rdest, i_rd_wr, i_jump,
               i_ex_ready, i_wb_valid, i_wb_rdest, i_br_resolved, i_br_taken,
        input  o_dec_ready, o_issue_valid, o_flush, o_busy_map, o_stall_cnt
    );
    modport slave (
        input  i_dec_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used, i_rdest, i_rd_wr, i_jump,
               i_ex_ready, i_wb_valid, i_wb_rdest, i_br_resolved, i_br_taken,
        output o_dec_ready, o_issue_valid, o_flush, o_busy_map, o_stall_cnt
    );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: scoreboard issue controller with branch serialisation and fetch flush.
// Define ISSUE_CTRL_WB_BYPASS_EN to let a same-cycle writeback release a RAW hazard.
module issue_ctrl #(
    parameter int n_regs_p       = 32,
    parameter int flush_cycles_p = 2,
    parameter int wd_cnt_p       = 16
) (
    input logic         clk,
    input logic         rst,
    issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;
    localparam logic [n_regs_p-1:0] one_c = n_regs_p'(1);

    state_t              r_state;
    logic [3:0]          r_flush_cnt;
    logic [n_regs_p-1:0] r_busy;
    logic [wd_cnt_p-1:0] r_stall_cnt;
    logic [n_regs_p-1:0] w_clr, w_set, w_busy_eff;
    logic                w_hz, w_ready, w_issue;

    assign w_clr = bus.i_wb_valid ? one_c << bus.i_wb_rdest : '0;
    assign w_set = (w_issue & bus.i_rd_wr & (|bus.i_rdest)) ? one_c << bus.i_rdest : '0;
`ifdef ISSUE_CTRL_WB_BYPASS_EN
    assign w_busy_eff = r_busy & ~w_clr;
`else
    assign w_busy_eff = r_busy;
`endif
    assign w_hz    = (bus.i_rs1_used & w_busy_eff[bus.i_rs1]) | (bus.i_rs2_used & w_busy_eff[bus.i_rs2]);
    assign w_ready = (r_state == RUN) & ~w_hz & bus.i_ex_ready;
    assign w_issue = bus.i_dec_valid & w_ready;

    assign bus.o_dec_ready   = w_ready;
    assign bus.o_issue_valid = w_issue;
    assign bus.o_flush       = (r_state == FLUSH);
    assign bus.o_busy_map    = r_busy;
    assign bus.o_stall_cnt   = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_busy      <= '0;
            r_stall_cnt <= '0;
        end else begin
            // set is applied after clear so a same-register issue keeps the bit
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~one_c;
            if (bus.i_dec_valid & ~w_ready & ~&r_stall_cnt)
                r_stall_cnt <= r_stall_cnt + wd_cnt_p'(1);
            case (r_state)
                RUN: if (w_issue & bus.i_jump) r_state <= BR_WAIT;
                BR_WAIT: if (bus.i_br_resolved) begin
                    r_state     <= bus.i_br_taken ? FLUSH : RUN;
                    r_flush_cnt <= bus.i_br_taken ? 4'(flush_cycles_p) : 4'd0;
                end
                FLUSH: begin
                    r_flush_cnt <= r_flush_cnt - 4'd1;
                    if (r_flush_cnt == 4'd1) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end
endmodule
